// File: rtl/spi_write_sequencer.sv
// spi_write_sequencer: two-requester round-robin SPI mode-0 write master.
// Each accepted request becomes one 16-bit frame {1'b1, addr, data}, MSB
// first, framed by ncs setup/hold/gap intervals. Requests whose address is
// above MAX_ADDR are accepted and dropped with a one-cycle err pulse.
module spi_write_sequencer #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned NCS_SETUP = 4,
    parameter int unsigned NCS_HOLD  = 4,
    parameter int unsigned NCS_GAP   = 8,
    parameter logic [6:0]  MAX_ADDR  = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       sclk,
    output logic       ncs,
    output logic       copi,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic       err
);

    localparam int unsigned MAX_A = (CLK_DIV > NCS_SETUP) ? CLK_DIV : NCS_SETUP;
    localparam int unsigned MAX_B = (NCS_HOLD > NCS_GAP) ? NCS_HOLD : NCS_GAP;
    localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] LD_SETUP = CW'(NCS_SETUP - 1);
    localparam logic [CW-1:0] LD_HALF  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(NCS_HOLD - 1);
    localparam logic [CW-1:0] LD_GAP   = CW'(NCS_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_bit;
    logic [14:0]     r_shift;
    logic            r_last_grant;
    logic            r_id;
    logic            r_sclk;
    logic            r_ncs;
    logic            r_copi;
    logic            r_busy;
    logic            r_done;
    logic            r_done_id;
    logic            r_err;

    logic            w_idle;
    logic            w_pick1;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_accept;
    logic            w_bad;
    logic [6:0]      w_addr;
    logic [7:0]      w_data;
    logic [15:0]     w_frame;
    logic            w_cnt_zero;

    // Round-robin grant and selection of the winning request.
    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        // On a tie the requester not served last wins; r_last_grant=1 means req1.
        w_pick1    = req1_valid && (!req0_valid || !r_last_grant);
        w_grant1   = w_pick1;
        w_grant0   = req0_valid && !w_pick1;
        w_accept   = w_idle && (w_grant0 || w_grant1);
        w_addr     = w_pick1 ? req1_addr : req0_addr;
        w_data     = w_pick1 ? req1_data : req0_data;
        w_bad      = (w_addr > MAX_ADDR);
        w_frame    = {1'b1, w_addr, w_data};
        w_cnt_zero = (r_cnt == '0);
    end

    assign req0_ready = w_idle && w_grant0;
    assign req1_ready = w_idle && w_grant1;

    // Frame sequencer with registered pin and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_sclk       <= 1'b0;
            r_ncs        <= 1'b1;
            r_copi       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_done_id    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_pick1;
                        if (w_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= ST_SETUP;
                            r_id    <= w_pick1;
                            r_ncs   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_copi  <= w_frame[15];
                            r_shift <= w_frame[14:0];
                            r_cnt   <= LD_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_SHIFT;
                        r_bit   <= '0;
                        r_sclk  <= 1'b0;
                        r_cnt   <= LD_HALF;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (!r_sclk) begin
                        r_sclk <= 1'b1;
                        r_cnt  <= LD_HALF;
                    end else begin
                        // Falling sclk edge: next bit goes out while sclk is low.
                        r_sclk <= 1'b0;
                        if (r_bit == 4'd15) begin
                            r_state <= ST_HOLD;
                            r_cnt   <= LD_HOLD;
                        end else begin
                            r_bit   <= r_bit + 4'd1;
                            r_copi  <= r_shift[14];
                            r_shift <= {r_shift[13:0], 1'b0};
                            r_cnt   <= LD_HALF;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_GAP;
                        r_ncs   <= 1'b1;
                        r_copi  <= 1'b0;
                        r_cnt   <= LD_GAP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (w_cnt_zero) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sclk  <= 1'b0;
                    r_ncs   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sclk    = r_sclk;
    assign ncs     = r_ncs;
    assign copi    = r_copi;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign err     = r_err;

endmodule

// File: tb/tb_spi_write_sequencer.sv
// Bench for spi_write_sequencer: a timing-formula reference model predicts
// pins, handshakes and status every cycle for the default-parameter DUT; a
// second DUT with minimum parameters runs a back-to-back write pair.
module tb_spi_write_sequencer;

    localparam int S   = 4;
    localparam int D   = 4;
    localparam int H   = 4;
    localparam int G   = 8;
    localparam int FR  = S + 32 * D + H;
    localparam int PER = FR + G + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- default-parameter DUT ----------------
    logic       rst_n;
    logic       v0, v1, r0, r1;
    logic [6:0] a0, a1;
    logic [7:0] d0, d1;
    logic       sclk, ncs, copi, busy, done, done_id, err;

    spi_write_sequencer #(
        .CLK_DIV(D), .NCS_SETUP(S), .NCS_HOLD(H), .NCS_GAP(G), .MAX_ADDR(7'h04)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
        .sclk(sclk), .ncs(ncs), .copi(copi), .busy(busy),
        .done(done), .done_id(done_id), .err(err)
    );

    // Reference model state
    int          cyc = 0;
    bit          act = 0;
    int          a_cyc = 0;
    int          done_at = -1;
    int          err_at = -1;
    logic [15:0] m_frame = '0;
    logic        done_id_e = 1'b0;
    logic        last = 1'b1;
    logic [14:0] q0[$];
    logic [14:0] q1[$];
    bit          drop0 = 0, drop1 = 0, rst_pend = 0, reset_now = 0, rnd = 0;
    logic        prev_sclk = 1'b0, prev_ncs = 1'b1;
    logic [15:0] cap = '0;
    int          nedge = 0;

    function automatic logic [14:0] rand_req();
        logic [6:0] ad;
        if ($urandom_range(0, 7) == 0) ad = 7'($urandom_range(5, 127));
        else ad = 7'($urandom_range(0, 4));
        return {ad, 8'($urandom)};
    endfunction

    task automatic model_reset();
        act = 0; last = 1'b1; done_at = -1; err_at = -1;
        prev_ncs = 1'b1; prev_sclk = 1'b0;
    endtask

    // One clock cycle: check outputs, drive inputs, check handshake, update model.
    task automatic step();
        logic [6:0] e, m, obs;
        int k, j;
        logic g0, g1, id;
        logic [6:0] ad;
        logic [7:0] dt;
        @(negedge clk);
        cyc++;
        if (rst_pend) begin
            model_reset();
            rst_n = 1'b1;
            rst_pend = 0;
        end
        if (act && (cyc - a_cyc) >= PER) act = 0;
        // bits: ncs, sclk, copi, busy, done, done_id, err
        e = 7'b1000000;
        m = 7'b1111111;
        if (act) begin
            k = cyc - a_cyc;
            e[3] = 1'b1;
            if (k <= FR) begin
                e[6] = 1'b0;
                if (k <= S) begin
                    e[4] = m_frame[15];
                end else if (k <= S + 32 * D) begin
                    j = k - 1 - S;
                    e[5] = ((j % (2 * D)) >= D);
                    e[4] = m_frame[15 - j / (2 * D)];
                end else begin
                    m[4] = 1'b0;
                end
            end
        end
        if (cyc == done_at) begin
            e[2] = 1'b1;
            e[1] = done_id_e;
        end else begin
            m[1] = 1'b0;
        end
        if (cyc == err_at) e[0] = 1'b1;
        obs = {ncs, sclk, copi, busy, done, done_id, err};
        check("pins", 32'(obs & m), 32'(e & m));

        if (prev_ncs && !ncs) begin
            nedge = 0;
            cap = '0;
        end
        if (!ncs && sclk && !prev_sclk) begin
            cap = {cap[14:0], copi};
            nedge++;
        end
        if (!prev_ncs && ncs) begin
            check("frame", 32'(cap), 32'(m_frame));
            check("sclk_edges", 32'(nedge), 32'd16);
        end
        prev_sclk = sclk;
        prev_ncs  = ncs;

        if (drop0) begin v0 = 1'b0; drop0 = 0; end
        if (drop1) begin v1 = 1'b0; drop1 = 0; end
        if (rnd) begin
            if (q0.size() == 0 && $urandom_range(0, 3) == 0) q0.push_back(rand_req());
            if (q1.size() == 0 && $urandom_range(0, 3) == 0) q1.push_back(rand_req());
        end
        if (!v0 && q0.size() > 0) begin {a0, d0} = q0.pop_front(); v0 = 1'b1; end
        if (!v1 && q1.size() > 0) begin {a1, d1} = q1.pop_front(); v1 = 1'b1; end
        if (reset_now) begin
            rst_n = 1'b0;
            rst_pend = 1;
            reset_now = 0;
        end
        #1;
        g1 = v1 && !act && (!v0 || !last);
        g0 = v0 && !act && !g1;
        check("ready", 32'({r1, r0}), 32'({g1, g0}));
        if ((g0 || g1) && rst_n) begin
            id = g1;
            ad = g1 ? a1 : a0;
            dt = g1 ? d1 : d0;
            last = id;
            if (g1) drop1 = 1; else drop0 = 1;
            if (ad > 7'h04) begin
                err_at = cyc + 1;
            end else begin
                act = 1;
                a_cyc = cyc;
                m_frame = {1'b1, ad, dt};
                done_at = cyc + PER;
                done_id_e = id;
            end
        end
    endtask

    task automatic run_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((act || q0.size() > 0 || q1.size() > 0 || v0 || v1 ||
                cyc <= done_at || cyc <= err_at) && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    // ---------------- minimum-parameter DUT ----------------
    logic        m_rst_n, m_v0, m_v1, m_r0, m_r1;
    logic [6:0]  m_a0, m_a1;
    logic [7:0]  m_d0, m_d1;
    logic        m_sclk, m_ncs, m_copi, m_busy, m_done, m_done_id, m_err;
    logic [15:0] m_cap = '0;
    int          m_ne = 0;
    logic [15:0] m_frames[$];
    int          m_fcnt[$];
    logic        m_dids[$];
    bit          m_fin = 0;

    spi_write_sequencer #(
        .CLK_DIV(2), .NCS_SETUP(1), .NCS_HOLD(4), .NCS_GAP(1), .MAX_ADDR(7'h04)
    ) dut_min (
        .clk(clk), .rst_n(m_rst_n),
        .req0_valid(m_v0), .req0_addr(m_a0), .req0_data(m_d0), .req0_ready(m_r0),
        .req1_valid(m_v1), .req1_addr(m_a1), .req1_data(m_d1), .req1_ready(m_r1),
        .sclk(m_sclk), .ncs(m_ncs), .copi(m_copi), .busy(m_busy),
        .done(m_done), .done_id(m_done_id), .err(m_err)
    );

    always @(negedge m_ncs) m_ne <= 0;
    always @(posedge m_sclk) begin
        if (m_ncs === 1'b0) begin
            m_cap <= {m_cap[14:0], m_copi};
            m_ne  <= m_ne + 1;
        end
    end
    always @(posedge m_ncs) begin
        if (m_ne != 0) begin
            m_frames.push_back(m_cap);
            m_fcnt.push_back(m_ne);
        end
    end
    always @(negedge clk) if (m_done === 1'b1) m_dids.push_back(m_done_id);

    initial begin
        int n;
        m_rst_n = 1'b0; m_v0 = 1'b0; m_v1 = 1'b0;
        m_a0 = '0; m_a1 = '0; m_d0 = '0; m_d1 = '0;
        repeat (2) @(negedge clk);
        m_rst_n = 1'b1;
        @(negedge clk);
        m_v0 = 1'b1; m_a0 = 7'h02; m_d0 = 8'hAA;
        m_v1 = 1'b1; m_a1 = 7'h03; m_d1 = 8'h55;
        #1;
        check("min_first_grant", 32'({m_r1, m_r0}), 32'h1);
        @(negedge clk);
        m_v0 = 1'b0;
        n = 1;
        #1;
        while (!m_r1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("min_period", 32'(n), 32'(1 + 32 * 2 + 4 + 1 + 1));
        @(negedge clk);
        m_v1 = 1'b0;
        n = 0;
        while (m_dids.size() < 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("min_done_count", 32'(m_dids.size()), 32'd2);
        check("min_frame_count", 32'(m_frames.size()), 32'd2);
        if (m_frames.size() == 2 && m_dids.size() == 2) begin
            check("min_frame0", 32'(m_frames[0]), 32'h82AA);
            check("min_frame1", 32'(m_frames[1]), 32'h8355);
            check("min_edges0", 32'(m_fcnt[0]), 32'd16);
            check("min_edges1", 32'(m_fcnt[1]), 32'd16);
            check("min_done_id0", 32'(m_dids[0]), 32'd0);
            check("min_done_id1", 32'(m_dids[1]), 32'd1);
        end
        m_fin = 1;
    end

    // ---------------- main sequence ----------------
    initial begin
        int n, j;
        rst_n = 1'b0; rst_pend = 1;
        v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        step();

        // tie straight out of reset: req0 first, then req1
        q0.push_back({7'h00, 8'hF0});
        q1.push_back({7'h01, 8'h0F});
        run_idle("tie_wait", 700);

        // single write at the top address
        q0.push_back({7'h04, 8'h80});
        run_idle("single_wait", 400);

        // fairness: both held valid for six frames, then req1 alone
        for (int i = 0; i < 3; i++) begin
            q0.push_back({7'($urandom_range(0, 4)), 8'($urandom)});
            q1.push_back({7'($urandom_range(0, 4)), 8'($urandom)});
        end
        run_idle("fair_wait", 1200);
        for (int i = 0; i < 3; i++) q1.push_back({7'($urandom_range(0, 4)), 8'($urandom)});
        run_idle("solo_wait", 700);

        // bad address
        q1.push_back({7'h05, 8'h77});
        run_idle("bad_wait", 20);

        // reset during bit 8
        q0.push_back({7'h03, 8'h3C});
        n = 0;
        j = -1;
        while (n < 400) begin
            step();
            n++;
            j = act ? (cyc - a_cyc - 1 - S) : -1;
            if (j >= 0 && j / (2 * D) == 8) break;
        end
        check("bit8_reach", 32'(n < 400), 32'd1);
        reset_now = 1;
        step();
        step();
        run_idle("post_reset_wait", 50);

        // randomized traffic
        rnd = 1;
        repeat (6000) step();
        rnd = 0;
        run_idle("random_drain", 2000);

        n = 0;
        while (!m_fin && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("min_finish", 32'(m_fin), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
